// File: rtl/rect_fill_engine.sv
// Rectangle painter: raster-scans a clipped (x0,y0,w,h) box in SOLID or OUTLINE mode, one pixel per cycle.
// First pixel valid the cycle after start; a plotted pixel is held while plot_ready is low, skipped ones never stall.
module rect_fill_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           mode,
  input  logic [X_W-1:0] x0_in,
  input  logic [Y_W-1:0] y0_in,
  input  logic [X_W-1:0] w_in,
  input  logic [Y_W-1:0] h_in,
  input  logic [C_W-1:0] colour_in,
  input  logic           plot_ready,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] colour,
  output logic           plot,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

  localparam logic [X_W:0]   SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   SCR_H = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W:0]   XW1   = (X_W+1)'(1);
  localparam logic [Y_W:0]   YW1   = (Y_W+1)'(1);
  localparam logic [X_W-1:0] XI    = X_W'(1);
  localparam logic [Y_W-1:0] YI    = Y_W'(1);

  state_t         state;
  logic           mode_r;
  logic [X_W-1:0] x0_r, x_end_r;
  logic [Y_W-1:0] y0_r, y_end_r;
  logic [X_W:0]   x_last_r;
  logic [Y_W:0]   y_last_r;

  // Far edges are kept unclipped so OUTLINE only draws edges that are really on screen.
  logic [X_W:0] x_sum, x_clip;
  logic [Y_W:0] y_sum, y_clip;
  logic         empty;

  assign x_sum  = {1'b0, x0_in} + {1'b0, w_in} - XW1;
  assign y_sum  = {1'b0, y0_in} + {1'b0, h_in} - YW1;
  assign x_clip = (x_sum > SCR_W - XW1) ? SCR_W - XW1 : x_sum;
  assign y_clip = (y_sum > SCR_H - YW1) ? SCR_H - YW1 : y_sum;
  assign empty  = (w_in == '0) | (h_in == '0) |
                  ({1'b0, x0_in} >= SCR_W) | ({1'b0, y0_in} >= SCR_H);

  logic           at_xend, last, advance, nplot;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;

  assign at_xend = (x == x_end_r);
  assign last    = at_xend & (y == y_end_r);
  assign advance = ~plot | plot_ready;
  assign nx      = at_xend ? x0_r : x + XI;
  assign ny      = at_xend ? y + YI : y;
  assign nplot   = ~mode_r | (nx == x0_r) | ({1'b0, nx} == x_last_r) |
                   (ny == y0_r) | ({1'b0, ny} == y_last_r);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mode_r   <= 1'b0;
      x0_r     <= '0;
      y0_r     <= '0;
      x_end_r  <= '0;
      y_end_r  <= '0;
      x_last_r <= '0;
      y_last_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_r   <= mode;
            x0_r     <= x0_in;
            y0_r     <= y0_in;
            x_end_r  <= x_clip[X_W-1:0];
            y_end_r  <= y_clip[Y_W-1:0];
            x_last_r <= x_sum;
            y_last_r <= y_sum;
            colour   <= colour_in;
            busy     <= 1'b1;
            if (empty) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              // The top-left corner is an edge pixel in either mode.
              state <= DRAW;
              x     <= x0_in;
              y     <= y0_in;
              plot  <= 1'b1;
            end
          end
        end
        DRAW: begin
          if (advance) begin
            if (last) begin
              state <= FINISH;
              plot  <= 1'b0;
              done  <= 1'b1;
            end else begin
              x    <= nx;
              y    <= ny;
              plot <= nplot;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: a reference model queues expected pixels, a monitor pops them on each handshake.
module tb_rect_fill_engine;

  logic       clock = 1'b0;
  logic       reset, start, mode, plot_ready;
  logic [7:0] x0_in, w_in, x;
  logic [6:0] y0_in, h_in, y;
  logic [2:0] colour_in, colour;
  logic       plot, busy, done;

  int          n_cmp  = 0;
  int          n_err  = 0;
  int          hs_cnt = 0;
  logic [17:0] expq[$];

  rect_fill_engine dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .x0_in(x0_in), .y0_in(y0_in), .w_in(w_in), .h_in(h_in),
    .colour_in(colour_in), .plot_ready(plot_ready),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sampled just after the falling edge so inputs changed on that edge are already visible.
  always begin
    @(negedge clock);
    #1;
    if (plot === 1'b1 && plot_ready === 1'b1) begin
      hs_cnt++;
      if (expq.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL spurious_plot: observed pixel %0h expected none", {x, y, colour});
      end else begin
        check("pixel", {x, y, colour}, expq.pop_front());
      end
    end
  end

  task automatic push_model(input bit m, input int px0, input int py0, input int pw,
                            input int ph, input int c, output int npos);
    npos = 0;
    for (int yy = py0; yy < py0 + ph; yy++)
      for (int xx = px0; xx < px0 + pw; xx++)
        if (xx < 160 && yy < 120) begin
          npos++;
          if (!m || xx == px0 || xx == px0 + pw - 1 || yy == py0 || yy == py0 + ph - 1)
            expq.push_back({xx[7:0], yy[6:0], c[2:0]});
        end
  endtask

  // Returns at the falling edge of cycle T+1 (T = accepting edge).
  task automatic launch(input bit m, input int px0, input int py0, input int pw,
                        input int ph, input int c);
    @(negedge clock);
    start = 1'b1; mode = m;
    x0_in = px0[7:0]; y0_in = py0[6:0]; w_in = pw[7:0]; h_in = ph[6:0]; colour_in = c[2:0];
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input bit m, input int px0, input int py0,
                        input int pw, input int ph, input int c);
    int npos, cyc, h0, nexp;
    push_model(m, px0, py0, pw, ph, c, npos);
    nexp = expq.size();
    h0   = hs_cnt;
    launch(m, px0, py0, pw, ph, c);
    check({tag, "_busy"}, busy, 1);
    wait_done(1, cyc);
    check({tag, "_done_cycle"}, cyc, (npos == 0) ? 1 : npos + 1);
    check({tag, "_plot_at_done"}, plot, 0);
    @(negedge clock);
    check({tag, "_idle_after"}, {busy, done}, 2'b00);
    check({tag, "_left_in_queue"}, expq.size(), 0);
    check({tag, "_handshakes"}, hs_cnt - h0, nexp);
  endtask

  initial begin
    int npos, cyc, h0;
    reset = 1'b1; start = 1'b1; mode = 1'b0; plot_ready = 1'b1;
    x0_in = 8'd3; y0_in = 7'd3; w_in = 8'd2; h_in = 7'd2; colour_in = 3'd7;

    // Reset held two cycles with start asserted.
    repeat (2) @(negedge clock);
    check("reset_outputs", {x, y, colour, plot, busy, done}, 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    check("post_reset_idle", {plot, busy, done}, 3'b000);

    run_op("solid_3x2", 1'b0, 5, 10, 3, 2, 5);
    run_op("outline_4x3", 1'b1, 0, 0, 4, 3, 2);
    run_op("outline_5x4", 1'b1, 30, 40, 5, 4, 3);
    run_op("outline_1xN", 1'b1, 9, 9, 1, 3, 4);
    run_op("clip_corner", 1'b0, 158, 119, 4, 3, 6);
    run_op("zero_w", 1'b0, 10, 10, 0, 5, 1);
    run_op("offscreen_x", 1'b0, 160, 5, 3, 3, 1);

    // Backpressure on the first pixel plus an ignored start mid-draw.
    push_model(1'b0, 0, 0, 2, 1, 2, npos);
    h0 = hs_cnt;
    plot_ready = 1'b0;
    launch(1'b0, 0, 0, 2, 1, 2);
    for (int i = 1; i <= 3; i++) begin
      check("bp_hold_xy", {x, y}, 0);
      check("bp_hold_plot", plot, 1);
      if (i == 2) begin
        start = 1'b1; mode = 1'b1; x0_in = 8'd50; w_in = 8'd5; h_in = 7'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    plot_ready = 1'b1;
    check("bp_hold_xy_4th", {x, y, plot}, 16'h0001);
    wait_done(4, cyc);
    check("bp_done_cycle", cyc, 6);
    @(negedge clock);
    check("bp_idle_after", {busy, done}, 2'b00);
    check("bp_handshakes", hs_cnt - h0, 2);
    check("bp_left_in_queue", expq.size(), 0);

    // Reset in the middle of an 8x8 fill.
    push_model(1'b0, 20, 20, 8, 8, 6, npos);
    h0 = hs_cnt;
    launch(1'b0, 20, 20, 8, 8, 6);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_quiet", {plot, busy, done}, 3'b000);
    check("midreset_handshakes", hs_cnt - h0, 5);
    expq.delete();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("midreset_no_done", {plot, busy, done}, 3'b000);
    end
    run_op("after_reset", 1'b0, 100, 50, 2, 2, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
